// File: rtl/tpu_seq.sv
// tpu_seq: host-access decoder and compute sequencer for a DIM x DIM systolic array.
// Optional performance counter built when TPU_SEQ_PERF_EN is defined.
module tpu_seq #(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    r_w,
    input  logic [ADDRW-1:0]        addr,
    output logic                    a_wr_en,
    output logic [$clog2(DIM)-1:0]  a_row,
    output logic                    a_en,
    output logic                    b_en,
    output logic                    sa_en,
    output logic                    sa_wr_en,
    output logic [$clog2(DIM)-1:0]  c_row,
    output logic [1:0]              rd_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNTW-1:0]         perf_cnt
);
    localparam int RW   = $clog2(DIM);
    localparam int TW   = $clog2(3*DIM);
    localparam int LAST = 3*DIM - 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, nxt;
    logic [TW-1:0]   cnt;
    logic [3:0]      region;
    logic [RW-1:0]   row;
    logic            start;
    logic            unused_bits;

    assign region      = addr[11:8];
    assign row         = addr[3 +: RW];
    assign unused_bits = ^addr;

    always_comb begin
        nxt      = state;
        a_wr_en  = 1'b0;
        a_row    = '0;
        a_en     = 1'b0;
        b_en     = 1'b0;
        sa_en    = 1'b0;
        sa_wr_en = 1'b0;
        c_row    = '0;
        rd_sel   = 2'd0;
        err      = 1'b0;
        start    = 1'b0;
        busy     = rst_n && state != IDLE;
        done     = rst_n && state == DONE;
        if (state == RUN) begin
            if (cnt == TW'(LAST)) nxt = DONE;
            a_en  = rst_n;
            b_en  = rst_n;
            sa_en = rst_n;
        end
        if (state == DONE) nxt = IDLE;
        // datapath strobes only fire in IDLE; status reads are allowed anytime
        if (req && rst_n) begin
            case (region)
                4'h1: if (!busy && r_w) begin
                        a_wr_en = 1'b1;
                        a_row   = row;
                    end else err = 1'b1;
                4'h2: if (!busy && r_w) b_en = 1'b1;
                    else err = 1'b1;
                4'h3: if (!busy) begin
                        c_row    = row;
                        sa_wr_en = r_w;
                        rd_sel   = r_w ? 2'd0 : 2'd1;
                    end else err = 1'b1;
                4'h4: if (!busy && r_w) begin
                        start = 1'b1;
                        nxt   = RUN;
                    end else err = 1'b1;
                4'h5: if (r_w) err = 1'b1;
                    else if (!addr[3]) rd_sel = 2'd2;
`ifdef TPU_SEQ_PERF_EN
                    else rd_sel = 2'd3;
`else
                    else err = 1'b1;
`endif
                default: err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (start) cnt <= '0;
            else if (state == RUN) cnt <= cnt + TW'(1);
        end
    end

`ifdef TPU_SEQ_PERF_EN
    logic [CNTW-1:0] perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf <= '0;
        else if (start && addr[0]) perf <= '0;
        else if (state == RUN && perf != '1) perf <= perf + CNTW'(1);
    end

    assign perf_cnt = perf;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_tpu_seq.sv
// tb_tpu_seq: directed bench for tpu_seq with a cycle-level behavioural model and per-cycle compare.
module tb_tpu_seq;
    localparam int DIM   = 8;
    localparam int ADDRW = 16;
    localparam int CNTW  = 16;
    localparam int RUNL  = 3*DIM - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic r_w = 1'b0;
    logic [ADDRW-1:0] addr = '0;
    logic a_wr_en, a_en, b_en, sa_en, sa_wr_en, busy, done, err;
    logic [$clog2(DIM)-1:0] a_row, c_row;
    logic [1:0] rd_sel;
    logic [CNTW-1:0] perf_cnt;

    int checks = 0;
    int failures = 0;
    int run_left = 0;
    bit in_done = 0;
    int perf_m = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    tpu_seq #(.DIM(DIM), .ADDRW(ADDRW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr),
        .a_wr_en(a_wr_en), .a_row(a_row), .a_en(a_en), .b_en(b_en),
        .sa_en(sa_en), .sa_wr_en(sa_wr_en), .c_row(c_row), .rd_sel(rd_sel),
        .busy(busy), .done(done), .err(err), .perf_cnt(perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a compute is simply "RUNL cycles of work, then one done cycle".
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_left = 0;
            in_done  = 0;
            perf_m   = 0;
        end else begin
            bit was_idle;
            was_idle = (run_left == 0) && !in_done;
            if (in_done) in_done = 0;
            else if (run_left > 0) begin
                run_left = run_left - 1;
                if (perf_m < (1 << CNTW) - 1) perf_m = perf_m + 1;
                if (run_left == 0) in_done = 1;
            end
            if (was_idle && req && r_w && ((addr >> 8) % 16) == 4) begin
                run_left = RUNL;
                if (addr % 2 == 1) perf_m = 0;
            end
        end
    end

    always @(negedge clk) begin
        int rg, rw_idx, e_awr, e_arow, e_ben, e_sawr, e_crow, e_rd, e_err, e_run, e_busy, e_perf;
        rg     = (addr >> 8) % 16;
        rw_idx = (addr >> 3) % DIM;
        e_run  = (rst_n && run_left > 0) ? 1 : 0;
        e_busy = (rst_n && (run_left > 0 || in_done)) ? 1 : 0;
        e_awr = 0; e_arow = 0; e_ben = e_run; e_sawr = 0; e_crow = 0; e_rd = 0; e_err = 0;
        if (rst_n && req) begin
            if (rg == 5) begin
                if (r_w) e_err = 1;
                else if ((addr >> 3) % 2 == 0) e_rd = 2;
`ifdef TPU_SEQ_PERF_EN
                else e_rd = 3;
`else
                else e_err = 1;
`endif
            end else if (rg < 1 || rg > 5 || e_busy == 1) e_err = 1;
            else if (rg == 3) begin
                e_crow = rw_idx;
                e_sawr = r_w;
                e_rd   = r_w ? 0 : 1;
            end else if (!r_w) e_err = 1;
            else if (rg == 1) begin
                e_awr  = 1;
                e_arow = rw_idx;
            end else if (rg == 2) e_ben = 1;
        end
`ifdef TPU_SEQ_PERF_EN
        e_perf = perf_m;
`else
        e_perf = 0;
`endif
        chk("a_wr_en", a_wr_en, e_awr);
        chk("a_row", a_row, e_arow);
        chk("a_en", a_en, e_run);
        chk("b_en", b_en, e_ben);
        chk("sa_en", sa_en, e_run);
        chk("sa_wr_en", sa_wr_en, e_sawr);
        chk("c_row", c_row, e_crow);
        chk("rd_sel", rd_sel, e_rd);
        chk("busy", busy, e_busy);
        chk("done", done, (rst_n && in_done) ? 1 : 0);
        chk("err", err, e_err);
        chk("perf_cnt", perf_cnt, e_perf);
        if (a_en) en_cnt++;
        if (done) done_cnt++;
    end

    task automatic acc(input bit rw, input logic [ADDRW-1:0] a);
        req = 1'b1; r_w = rw; addr = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req = 1'b0; r_w = 1'b0; addr = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4*RUNL && busy; i++) tick();
        chk("run_terminates", busy, 0);
    endtask

    initial begin
        int e0, d0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        acc(1, 16'h0118);
        chk("lit_a_wr_en_0118", a_wr_en, 1);
        chk("lit_a_row_0118", a_row, 3);
        chk("lit_err_0118", err, 0);
        tick();
        acc(1, 16'h01F8); chk("lit_row_trunc", a_row, 7); tick();
        acc(1, 16'hF118); chk("lit_high_bits", a_row, 3); tick();
        acc(0, 16'h0118); chk("lit_a_read_err", err, 1); tick();
        acc(1, 16'h0200); chk("lit_b_write", b_en, 1); tick();
        acc(1, 16'h0320); chk("lit_c_write_row", c_row, 4); chk("lit_c_wr", sa_wr_en, 1); tick();
        acc(0, 16'h0338); chk("lit_c_read_sel", rd_sel, 1); tick();
        acc(0, 16'h0400); chk("lit_cmd_read_err", err, 1); tick();
        acc(1, 16'h0700);
        chk("lit_region7_err", err, 1);
        chk("lit_region7_strobes", {a_wr_en, b_en, sa_wr_en, a_en}, 0);
        tick();
        acc(0, 16'h0500); chk("lit_status_sel", rd_sel, 2); tick();
`ifndef TPU_SEQ_PERF_EN
        acc(0, 16'h0508); chk("lit_cnt_read_err", err, 1); chk("lit_cnt_read_sel", rd_sel, 0); tick();
`endif

        e0 = en_cnt; d0 = done_cnt;
        acc(1, 16'h0400); chk("lit_busy_before", busy, 0); tick();
        chk("lit_busy_after_cmd", busy, 1);
        acc(1, 16'h0200); chk("lit_busy_b_err", err, 1); chk("lit_busy_b_en", b_en, 1); tick();
        acc(0, 16'h0500); chk("lit_busy_status", rd_sel, 2); chk("lit_busy_status_err", err, 0); tick();
        wait_idle();
        chk("lit_run_len", en_cnt - e0, 22);
        chk("lit_done_pulses", done_cnt - d0, 1);

        d0 = done_cnt;
        acc(1, 16'h0400); tick();
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_en", {a_en, b_en, sa_en, done}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("lit_no_done_after_abort", done_cnt - d0, 0);
        e0 = en_cnt;
        acc(1, 16'h0400); tick();
        wait_idle();
        chk("lit_run_after_reset", en_cnt - e0, 22);

`ifdef TPU_SEQ_PERF_EN
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        acc(1, 16'h0400); tick(); wait_idle();
        acc(1, 16'h0400); tick(); wait_idle();
        acc(0, 16'h0508); chk("lit_perf_sel", rd_sel, 3); chk("lit_perf_44", perf_cnt, 44); tick();
        acc(1, 16'h0401); tick(); wait_idle();
        chk("lit_perf_22", perf_cnt, 22);
`endif
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
